uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver; next generation of rx_core. Adds configurable frame format
//  (5-9 data bits, optional parity, 1/2 stop bits), a baud divider, and mid-bit majority vote.
//  Adds valid/ready output holding register plus error flags: framing, parity, overrun, break.
//  Sits between the pad and the UART Avalon slave register file / RX FIFO.
// PARAMETERS
//  DATA_BITS     8   data bits per frame, legal 5..9, LSB first
//  PARITY        0   0 none, 1 odd, 2 even
//  STOP_BITS     1   1 or 2; every stop bit is checked
//  CLKS_PER_BIT  16  rx_clk cycles per bit, legal >= 8
// PORTS
//  rx_clk     in   1          receiver clock
//  reset      in   1          synchronous, active-high reset
//  rx         in   1          serial line, asynchronous, idle high
//  rx_data    out  DATA_BITS  received word, valid while rx_valid=1
//  rx_valid   out  1          holding register full
//  rx_ready   in   1          consumer accepts when rx_valid&rx_ready on a rising edge
//  rx_done    out  1          one-cycle pulse at end of every frame, incl. errored frames
//  frame_err  out  1          sticky with rx_data: a stop bit sampled low
//  parity_err out  1          sticky with rx_data: parity mismatch (0 when PARITY=0)
//  break_det  out  1          one-cycle pulse: data, parity and first stop bit all 0
//  overrun    out  1          sticky; set when a frame completes while holding reg full
//  busy       out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, and synchronizer flops loaded with 1.
//  Reset mid-frame aborts the frame with no rx_done.
//  Input: 2-flop synchronizer; all references to rx below mean the synchronized value.
//  Timing: bit counter runs 0..CLKS_PER_BIT-1. Mid point M = CLKS_PER_BIT/2.
//  Bit value: majority of samples at M-1, M, M+1.
//  FSM IDLE -> START: on rx 1->0 transition; counter cleared.
//  FSM START: vote at M. If result is 1, this is a false start: return to IDLE, no flags.
//  If result is 0, counter realigns so later votes land mid-bit.
//  FSM START -> DATA.
//  FSM DATA: DATA_BITS votes, shifted in LSB first.
//  FSM DATA -> PARITY when PARITY!=0, else DATA -> STOP.
//  FSM PARITY: odd parity = ^data ^ p must be 1; even parity requires 0.
//  FSM STOP: STOP_BITS votes; any 0 vote sets frame error.
//  FSM STOP -> IDLE on the cycle after the last stop vote, without waiting for the bit end,
//  so a back-to-back start bit is caught.
//  Frame completion (cycle C, one cycle after last stop vote): rx_done=1 for one cycle.
//  If holding reg empty, or being drained in cycle C (rx_valid&rx_ready), then in C:
//  rx_data, frame_err, parity_err load and rx_valid=1.
//  Else the new frame is dropped, the old word kept, overrun<=1.
//  overrun clears only on a handshake that drains the holding register.
//  break_det pulses in C. During break, FSM waits in IDLE for rx=1 before re-arming.
//  Handshake: rx_valid falls the cycle after rx_valid&rx_ready unless a new frame loads then.
//  rx_data is unchanged while rx_valid=1 and not accepted.
//  Latency: line falling edge to rx_done =
//  2 + (1+DATA_BITS+(PARITY!=0)+STOP_BITS-1)*CLKS_PER_BIT + M + 2 cycles, +/-1 for vote.
//  Width rule: rx_data upper bits beyond DATA_BITS do not exist; no zero padding inside.
// TESTING
//  (CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1 unless stated)
//  T1: send 0xA5 with even parity bit 0, rx_ready=1.
//      -> one rx_done, rx_data=0xA5, no error flags; repeat 50 random bytes, all match.
//  T2: 0x3C sent with parity bit 1.
//      -> rx_data=0x3C, parity_err=1; next correct frame clears it.
//  T3: 0x81 with stop bit driven 0.
//      -> frame_err=1, rx_done pulses; FSM in IDLE; next frame 0x7E received clean.
//  T4: rx_ready=0, send 0x11 then 0x22.
//      -> rx_data stays 0x11, overrun=1; then rx_ready=1 for one cycle.
//      -> rx_valid falls, overrun=0.
//  T5: 6-cycle low glitch on idle line.
//      -> false start, no rx_done, busy returns 0 within 9 cycles.
//      Line held low 12 bit times -> break_det=1, frame_err=1, then re-arm after rx=1.
//  T6: assert reset mid DATA of 0x55.
//      -> no rx_done, all outputs 0; next frame 0x99 received correctly.
//      Also rerun T1 with DATA_BITS=7, PARITY=1, STOP_BITS=2.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receiver with 2-flop synchronizer and a 3-sample mid-bit majority vote.
// It supports 5-9 data bits, optional parity, 1 or 2 stop bits, and a valid/ready holding register.
module uart_rx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 rx_clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int MID   = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] C_S0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] C_S1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] C_VOTE = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       C_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       C_SLAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2, r_rx_d;
  logic [CNT_W-1:0]      r_cnt;
  logic [3:0]            r_idx;
  logic                  r_s0, r_s1;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par, r_stop0, r_fe;
  logic [DATA_BITS-1:0]  r_data;
  logic                  r_valid, r_done, r_fe_out, r_pe_out, r_break, r_overrun;

  logic w_rx, w_vote, w_at_vote, w_par_x, w_pe, w_fe, w_stop0, w_brk;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_rx       = r_sync2;
  assign w_vote     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_at_vote  = (r_cnt == C_VOTE);
  assign w_cnt_next = (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
  assign w_par_x    = ^r_shift ^ r_par;
  assign w_pe       = (PARITY == 0) ? 1'b0 : ((PARITY == 1) ? ~w_par_x : w_par_x);
  assign w_fe       = r_fe | ~w_vote;
  assign w_stop0    = (r_idx == 4'd0) ? w_vote : r_stop0;
  assign w_brk      = (r_shift == '0) && ((PARITY == 0) || !r_par) && !w_stop0;

  // rx_valid holds the word until rx_valid & rx_ready meet at a rising edge;
  // a frame completing in that same cycle reloads the register without overrun.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_d    <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_stop0   <= 1'b0;
      r_fe      <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_fe_out  <= 1'b0;
      r_pe_out  <= 1'b0;
      r_break   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
      r_done  <= 1'b0;
      r_break <= 1'b0;
      if (r_valid && rx_ready) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
      // The counter free-runs at the bit period, so every vote keeps the start-bit phase.
      if (r_state != S_IDLE) begin
        r_cnt <= w_cnt_next;
        if (r_cnt == C_S0) r_s0 <= w_rx;
        if (r_cnt == C_S1) r_s1 <= w_rx;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_rx && r_rx_d) begin
            r_state <= S_START;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_fe    <= 1'b0;
          end
        end
        S_START: begin
          if (w_at_vote) r_state <= w_vote ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (w_at_vote) begin
            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (r_idx == C_DLAST) begin
              r_idx   <= '0;
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_at_vote) begin
            r_par   <= w_vote;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_at_vote) begin
            if (r_idx == 4'd0) r_stop0 <= w_vote;
            r_fe <= w_fe;
            if (r_idx == C_SLAST) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_break <= w_brk;
              if (!r_valid || rx_ready) begin
                r_data   <= r_shift;
                r_fe_out <= w_fe;
                r_pe_out <= w_pe;
                r_valid  <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign rx_done    = r_done;
  assign frame_err  = r_fe_out;
  assign parity_err = r_pe_out;
  assign break_det  = r_break;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8E1 instance (a) and a 7O2 instance (b),
// with frames driven bit by bit and outputs captured on the rx_done cycle.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       valid_a, done_a, fe_a, pe_a, brk_a, ovr_a, busy_a;
  logic       valid_b, done_b, fe_b, pe_b, brk_b, ovr_b, busy_b;
  logic [2:0] dbg_a, dbg_b;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  logic       cap_found;
  int         cap_lat;
  logic [8:0] cap_data;
  logic       cap_valid, cap_fe, cap_pe, cap_brk, cap_ovr, cap_busy;
  logic [8:0] exp_q[$];

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) u_dut_a (
    .rx_clk(clk), .reset(reset), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .rx_done(done_a), .frame_err(fe_a), .parity_err(pe_a),
    .break_det(brk_a), .overrun(ovr_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) u_dut_b (
    .rx_clk(clk), .reset(reset), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .rx_done(done_b), .frame_err(fe_b), .parity_err(pe_b),
    .break_det(brk_b), .overrun(ovr_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic drive_bits(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      repeat (CPB) @(negedge clk);
    end
    set_line(sel, 1'b1);
  endtask

  task automatic wait_done(input int sel, input int budget);
    cap_found = 1'b0;
    cap_lat   = 0;
    for (int i = 1; i <= budget && !cap_found; i++) begin
      @(negedge clk);
      if (sel == 0 && done_a) begin
        cap_found = 1'b1; cap_lat = i; cap_data = {1'b0, data_a}; cap_valid = valid_a;
        cap_fe = fe_a; cap_pe = pe_a; cap_brk = brk_a; cap_ovr = ovr_a; cap_busy = busy_a;
      end else if (sel == 1 && done_b) begin
        cap_found = 1'b1; cap_lat = i; cap_data = {2'b00, data_b}; cap_valid = valid_b;
        cap_fe = fe_b; cap_pe = pe_b; cap_brk = brk_b; cap_ovr = ovr_b; cap_busy = busy_b;
      end
    end
  endtask

  task automatic frame_a(input logic [7:0] d, input logic p, input logic stp);
    logic [15:0] b;
    int d0;
    b = 16'hFFFF;
    b[0] = 1'b0; b[8:1] = d; b[9] = p; b[10] = stp;
    d0 = done_cnt_a;
    fork
      drive_bits(0, b, 11);
      wait_done(0, 400);
    join
    check("a_done_found", 32'(cap_found), 32'd1);
    check("a_done_count", 32'(done_cnt_a - d0), 32'd1);
  endtask

  task automatic frame_b(input logic [6:0] d, input logic p, input logic s0, input logic s1);
    logic [15:0] b;
    int d0;
    b = 16'hFFFF;
    b[0] = 1'b0; b[7:1] = d; b[8] = p; b[9] = s0; b[10] = s1;
    d0 = done_cnt_b;
    fork
      drive_bits(1, b, 11);
      wait_done(1, 400);
    join
    check("b_done_found", 32'(cap_found), 32'd1);
    check("b_done_count", 32'(done_cnt_b - d0), 32'd1);
  endtask

  initial begin
    logic [7:0] rnd;
    logic [8:0] exp_w;
    logic       found;
    int         d0;

    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    idle(4);
    check("reset_a_outputs", 32'({data_a, valid_a, done_a, fe_a, pe_a, brk_a, ovr_a, busy_a}), 32'd0);
    check("reset_b_outputs", 32'({data_b, valid_b, done_b, fe_b, pe_b, brk_b, ovr_b, busy_b}), 32'd0);
    check("reset_a_state", 32'(dbg_a), 32'd0);
    reset = 1'b0;
    idle(4);

    // T1: clean frame, latency, then random bytes back to back
    frame_a(8'hA5, 1'b0, 1'b1);
    check("t1_data", 32'(cap_data), 32'h0A5);
    check("t1_valid", 32'(cap_valid), 32'd1);
    check("t1_flags", 32'({cap_fe, cap_pe, cap_brk, cap_ovr}), 32'd0);
    check("t1_latency_window", 32'(cap_lat >= 171 && cap_lat <= 174), 32'd1);
    check("t1_valid_drained", 32'(valid_a), 32'd0);
    for (int i = 0; i < 50; i++) begin
      rnd = 8'($urandom_range(0, 255));
      exp_q.push_back({1'b0, rnd});
      frame_a(rnd, ^rnd, 1'b1);
      exp_w = exp_q.pop_front();
      check("t1_rand_data", 32'(cap_data), 32'(exp_w));
      check("t1_rand_flags", 32'({cap_fe, cap_pe, cap_brk}), 32'd0);
    end

    // T2: wrong parity, then a correct frame clears the flag
    frame_a(8'h3C, 1'b1, 1'b1);
    check("t2_data", 32'(cap_data), 32'h03C);
    check("t2_parity_err", 32'(cap_pe), 32'd1);
    check("t2_frame_err", 32'(cap_fe), 32'd0);
    frame_a(8'h3C, 1'b0, 1'b1);
    check("t2_parity_clear", 32'(cap_pe), 32'd0);

    // T3: stop bit low
    frame_a(8'h81, 1'b0, 1'b0);
    check("t3_frame_err", 32'(cap_fe), 32'd1);
    check("t3_data", 32'(cap_data), 32'h081);
    check("t3_no_break", 32'(cap_brk), 32'd0);
    check("t3_idle", 32'(cap_busy), 32'd0);
    idle(4);
    frame_a(8'h7E, 1'b0, 1'b1);
    check("t3_next_data", 32'(cap_data), 32'h07E);
    check("t3_next_flags", 32'({cap_fe, cap_pe, cap_brk}), 32'd0);

    // T4: overrun while the consumer stalls
    ready_a = 1'b0;
    frame_a(8'h11, 1'b0, 1'b1);
    check("t4_first_data", 32'(cap_data), 32'h011);
    frame_a(8'h22, 1'b0, 1'b1);
    check("t4_held_data", 32'(cap_data), 32'h011);
    check("t4_overrun", 32'(cap_ovr), 32'd1);
    check("t4_still_valid", 32'(valid_a), 32'd1);
    check("t4_accept_data", 32'(data_a), 32'h11);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    check("t4_valid_fall", 32'(valid_a), 32'd0);
    check("t4_overrun_clear", 32'(ovr_a), 32'd0);
    ready_a = 1'b1;
    idle(4);

    // T5: short glitch is a false start
    d0 = done_cnt_a;
    rx_a = 1'b0;
    idle(6);
    rx_a = 1'b1;
    check("t5_glitch_busy", 32'(busy_a), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 9 && !found; i++) begin
      @(negedge clk);
      if (!busy_a) found = 1'b1;
    end
    check("t5_busy_clear", 32'(found), 32'd1);
    idle(40);
    check("t5_no_done", 32'(done_cnt_a - d0), 32'd0);

    // T5: break, held low 12 bit times and beyond; no re-arm until the line rises
    d0 = done_cnt_a;
    fork
      begin rx_a = 1'b0; repeat (12 * CPB) @(negedge clk); end
      wait_done(0, 400);
    join
    check("t5_break_done", 32'(cap_found), 32'd1);
    check("t5_break_det", 32'(cap_brk), 32'd1);
    check("t5_break_fe", 32'(cap_fe), 32'd1);
    check("t5_break_data", 32'(cap_data), 32'd0);
    idle(32);
    check("t5_break_idle", 32'(busy_a), 32'd0);
    check("t5_break_pulse_gone", 32'(brk_a), 32'd0);
    check("t5_break_one_done", 32'(done_cnt_a - d0), 32'd1);
    rx_a = 1'b1;
    idle(8);
    frame_a(8'h5A, 1'b0, 1'b1);
    check("t5_rearm_data", 32'(cap_data), 32'h05A);
    check("t5_rearm_flags", 32'({cap_fe, cap_pe, cap_brk}), 32'd0);

    // T6: reset mid-data with a full holding register
    ready_a = 1'b0;
    frame_a(8'h3C, 1'b1, 1'b1);
    check("t6_pre_pe", 32'(cap_pe), 32'd1);
    d0 = done_cnt_a;
    drive_bits(0, 16'hFEAA, 5);
    check("t6_busy_mid", 32'(busy_a), 32'd1);
    reset = 1'b1;
    idle(2);
    check("t6_reset_outputs", 32'({data_a, valid_a, done_a, fe_a, pe_a, brk_a, ovr_a, busy_a}), 32'd0);
    reset = 1'b0;
    ready_a = 1'b1;
    idle(200);
    check("t6_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("t6_idle", 32'(busy_a), 32'd0);
    frame_a(8'h99, 1'b0, 1'b1);
    check("t6_next_data", 32'(cap_data), 32'h099);
    check("t6_next_flags", 32'({cap_fe, cap_pe, cap_brk}), 32'd0);

    // 7 data bits, odd parity, two stop bits
    frame_b(7'h25, 1'b0, 1'b1, 1'b1);
    check("b_data_25", 32'(cap_data), 32'h025);
    check("b_flags_25", 32'({cap_fe, cap_pe, cap_brk}), 32'd0);
    check("b_latency_window", 32'(cap_lat >= 171 && cap_lat <= 174), 32'd1);
    frame_b(7'h5A, 1'b1, 1'b1, 1'b1);
    check("b_data_5a", 32'(cap_data), 32'h05A);
    check("b_flags_5a", 32'({cap_fe, cap_pe, cap_brk}), 32'd0);
    frame_b(7'h25, 1'b1, 1'b1, 1'b1);
    check("b_parity_err", 32'(cap_pe), 32'd1);
    frame_b(7'h5A, 1'b1, 1'b1, 1'b0);
    check("b_second_stop_fe", 32'(cap_fe), 32'd1);
    check("b_second_stop_pe", 32'(cap_pe), 32'd0);
    idle(4);
    frame_b(7'h40, 1'b0, 1'b1, 1'b1);
    check("b_data_msb", 32'(cap_data), 32'h040);
    check("b_flags_msb", 32'({cap_fe, cap_pe, cap_brk}), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
